mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_array.sv | 48 ++++
 rtl/mem_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// ============================================================================
//  Module   : mem_responder_pkg
//  Purpose  : Shared defaults and FSM state encoding for the memory responder.
//  Contents : DATA_W_DEF / ADDR_W_DEF / DEPTH_DEF defaults, state_t enum.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

    localparam int DATA_W_DEF = 17;
    localparam int ADDR_W_DEF = 17;
    localparam int DEPTH_DEF  = 1024;

    // SERVE      : accept one fetch or one data request per cycle
    // FETCH_OWED : complete the fetch deferred by a fetch/data collision
    typedef enum logic [0:0] {
        SERVE      = 1'b0,
        FETCH_OWED = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
//  Module   : mem_array
//  Purpose  : Single-port DEPTH x DATA_W storage, synchronous write,
//             registered read. One access (read or write) per enabled cycle.
//  Ports    : clk   - clock
//             en    - access enable
//             we    - write when en is high, otherwise read
//             addr  - word index
//             wdata - write data
//             rdata - registered read data (holds when no read happens)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_array
    import mem_responder_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Contents are deliberately not reset.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Single-port memory shared by an instruction-fetch port and a
//             data port. Data wins a same-cycle collision; the fetch is
//             latched and served the following cycle while stall is high.
//             Latency 1 for both ports.
//  Ports    : clk, rst (sync, active high)
//             if_req/if_addr -> instr/instr_valid        (fetch port)
//             mem_re/mem_we/mem_addr/mem_wdata
//                            -> mem_rdata/mem_rvalid     (data port)
//             stall - high during the owed-fetch cycle
//             err   - out-of-range access pulse
//  Config   : `define MEM_BOUNDS_CHECK_EN to flag addresses >= DEPTH (err
//             pulse, write suppressed, reads return 0). Undefined: addresses
//             wrap modulo DEPTH and err stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rvalid,
    output logic              stall,
    output logic              err
);

    localparam int c_IDX_W = $clog2(DEPTH);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              r_instr_valid;
    logic              r_rvalid;
    logic              r_stall;
    logic              r_err;
    logic              r_oob;
    logic [DATA_W-1:0] r_instr_hold;
    logic [DATA_W-1:0] r_rdata_hold;

    logic              w_data_req;
    logic              w_acc_en;
    logic              w_acc_we;
    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_oob;
    logic [DATA_W-1:0] w_arr_rdata;
    logic [DATA_W-1:0] w_rd_value;

    // Select the single array access for this cycle: owed fetch first,
    // then data, then a lone fetch.
    always_comb begin
        w_data_req = mem_we | mem_re;
        w_acc_addr = mem_addr;
        w_acc_en   = 1'b0;
        w_acc_we   = 1'b0;
        if (r_state == FETCH_OWED) begin
            w_acc_addr = r_pend_addr;
            w_acc_en   = 1'b1;
        end else if (w_data_req) begin
            w_acc_addr = mem_addr;
            w_acc_en   = 1'b1;
            w_acc_we   = mem_we;
        end else if (if_req) begin
            w_acc_addr = if_addr;
            w_acc_en   = 1'b1;
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    assign w_oob = |w_acc_addr[ADDR_W-1:c_IDX_W];
`else
    // Upper address bits are simply dropped, giving modulo-DEPTH wrap.
    logic w_unused_hi;
    assign w_unused_hi = ^w_acc_addr[ADDR_W-1:c_IDX_W];
    assign w_oob       = 1'b0;
`endif

    // Reset blocks any write sampled in the same cycle.
    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .en    (w_acc_en & ~rst),
        .we    (w_acc_we & ~w_oob & ~rst),
        .addr  (w_acc_addr[c_IDX_W-1:0]),
        .wdata (mem_wdata),
        .rdata (w_arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= SERVE;
            r_pend_addr   <= '0;
            r_instr_valid <= 1'b0;
            r_rvalid      <= 1'b0;
            r_stall       <= 1'b0;
            r_err         <= 1'b0;
            r_oob         <= 1'b0;
            r_instr_hold  <= '0;
            r_rdata_hold  <= '0;
        end else begin
            r_instr_valid <= 1'b0;
            r_rvalid      <= 1'b0;
            r_stall       <= 1'b0;
            r_err         <= w_acc_en & w_oob;
            r_oob         <= w_oob;
            // Capture the value being presented so it persists once the
            // array read port is reused by the other port.
            if (r_instr_valid) begin
                r_instr_hold <= w_rd_value;
            end
            if (r_rvalid) begin
                r_rdata_hold <= w_rd_value;
            end
            case (r_state)
                SERVE: begin
                    if (w_data_req) begin
                        r_rvalid <= mem_re & ~mem_we;
                        if (if_req) begin
                            r_pend_addr <= if_addr;
                            r_state     <= FETCH_OWED;
                            r_stall     <= 1'b1;
                        end
                    end else if (if_req) begin
                        r_instr_valid <= 1'b1;
                    end
                end
                FETCH_OWED: begin
                    r_instr_valid <= 1'b1;
                    r_state       <= SERVE;
                end
                default: r_state <= SERVE;
            endcase
        end
    end

    assign w_rd_value  = r_oob ? '0 : w_arr_rdata;
    assign instr       = r_instr_valid ? w_rd_value : r_instr_hold;
    assign mem_rdata   = r_rvalid ? w_rd_value : r_rdata_hold;
    assign instr_valid = r_instr_valid;
    assign mem_rvalid  = r_rvalid;
    assign stall       = r_stall;
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder. Each step drives one
//             cycle of requests, pushes the expected next-cycle outputs to a
//             scoreboard queue, and pops/compares them after the clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int DW    = 17;
    localparam int AW    = 17;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          stall;
    logic          err;

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .stall       (stall),
        .err         (err)
    );

    typedef struct packed {
        logic          ival;
        logic [DW-1:0] instr;
        logic          rval;
        logic [DW-1:0] rdata;
        logic          stall;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          m_prev;
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_owed;
    logic [AW-1:0] m_pend;
    int            checks = 0;
    int            passed = 0;
    logic [DW-1:0] rnd_data [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic logic is_oob(input logic [AW-1:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
        return int'(a) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (is_oob(a)) return '0;
        return m_mem[int'(a) % DEPTH];
    endfunction

    // One cycle: drive inputs, predict, wait for the edge, compare.
    task automatic step(input string tag, input logic r, input logic fr,
                        input logic [AW-1:0] fa, input logic re, input logic we,
                        input logic [AW-1:0] ma, input logic [DW-1:0] wd);
        exp_t e;
        exp_t got;
        rst = r; if_req = fr; if_addr = fa;
        mem_re = re; mem_we = we; mem_addr = ma; mem_wdata = wd;

        e       = m_prev;
        e.ival  = 1'b0;
        e.rval  = 1'b0;
        e.stall = 1'b0;
        e.err   = 1'b0;
        if (r) begin
            e.instr = '0;
            e.rdata = '0;
            m_owed  = 1'b0;
            m_pend  = '0;
        end else if (m_owed) begin
            m_owed  = 1'b0;
            e.ival  = 1'b1;
            e.instr = model_rd(m_pend);
            e.err   = is_oob(m_pend);
        end else if (re | we) begin
            e.err = is_oob(ma);
            if (we) begin
                if (!is_oob(ma)) m_mem[int'(ma) % DEPTH] = wd;
            end else begin
                e.rval  = 1'b1;
                e.rdata = model_rd(ma);
            end
            if (fr) begin
                m_owed  = 1'b1;
                m_pend  = fa;
                e.stall = 1'b1;
            end
        end else if (fr) begin
            e.ival  = 1'b1;
            e.instr = model_rd(fa);
            e.err   = is_oob(fa);
        end
        m_prev = e;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks = checks + 1;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end else begin
            got = exp_q.pop_front();
            chk({tag, "_ival"},  32'(instr_valid), 32'(got.ival));
            chk({tag, "_rval"},  32'(mem_rvalid),  32'(got.rval));
            chk({tag, "_stall"}, 32'(stall),       32'(got.stall));
            chk({tag, "_err"},   32'(err),         32'(got.err));
            chk({tag, "_instr"}, 32'(instr),       32'(got.instr));
            chk({tag, "_rdata"}, 32'(mem_rdata),   32'(got.rdata));
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        m_prev = '0;
        m_owed = 1'b0;
        m_pend = '0;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;

        // Reset state
        step("rst0", 1, 0, '0, 0, 0, '0, '0);
        step("rst1", 1, 0, '0, 0, 0, '0, '0);

        // Write then read back next cycle
        step("wr5", 0, 0, '0, 0, 1, 17'd5, 17'h1ABCD);
        step("rd5", 0, 0, '0, 1, 0, 17'd5, '0);
        step("wr3", 0, 0, '0, 0, 1, 17'd3, 17'h00007);
        step("if5", 0, 1, 17'd5, 0, 0, '0, '0);
        idle("idle0");

        // Fetch/data collision on the same address: write wins, fetch owed
        step("conf", 0, 1, 17'd5, 0, 1, 17'd5, 17'h00042);
        step("owed", 0, 1, 17'd5, 0, 1, 17'd5, 17'h00042);

        // Read and write together: write only
        step("rw7", 0, 0, '0, 1, 1, 17'd7, 17'h00003);
        step("rd7", 0, 0, '0, 1, 0, 17'd7, '0);
        idle("idle1");

        // Reset during FETCH_OWED; a write sampled under reset is dropped
        step("wr9",   0, 0, '0, 0, 1, 17'd9, 17'h00001);
        step("conf2", 0, 1, 17'd9, 1, 0, 17'd9, '0);
        step("rstow", 1, 1, 17'd9, 0, 1, 17'd9, 17'h00055);
        idle("post0");
        idle("post1");
        step("rd9", 0, 0, '0, 1, 0, 17'd9, '0);

        // Address beyond DEPTH
        step("wrap_w", 0, 0, '0, 0, 1, 17'(DEPTH + 3), 17'h00011);
        step("rd3",    0, 0, '0, 1, 0, 17'd3, '0);
        step("if_hi",  0, 1, 17'(DEPTH + 5), 0, 0, '0, '0);

        // Random data round trip through both ports
        for (int i = 0; i < 8; i++) begin
            rnd_data[i] = DW'($urandom);
            step("rnd_wr", 0, 0, '0, 0, 1, 17'(100 + i), rnd_data[i]);
        end
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                step("rnd_if", 0, 1, 17'(100 + i), 0, 0, '0, '0);
            else
                step("rnd_rd", 0, 0, '0, 1, 0, 17'(100 + i), '0);
        end

        // Collision with a data read: both ports deliver, fetch one cycle late
        step("conf3", 0, 1, 17'd101, 1, 0, 17'd102, '0);
        step("owed3", 0, 1, 17'd101, 1, 0, 17'd102, '0);
        idle("idle2");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
